// File: rtl/triangle_assembler.sv
`timescale 1ns/1ps
// triangle_assembler: packs a stream of 12 words into triangle records
// (three xyz vertices plus an attribute row). Two slots are used as a
// ping-pong buffer so that one triangle can be filled while the other
// waits for the pixel shader. Records with the wrong length are dropped
// and counted as framing errors.
module triangle_assembler #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [WORD_W-1:0]           word_in,
    input  logic                        word_valid_in,
    input  logic                        word_last_in,
    output logic                        word_ready_out,
    output logic [3:0][2:0][WORD_W-1:0] triangle_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [CNT_W-1:0]            tri_count_out,
    output logic                        err_out,
    output logic [CNT_W-1:0]            err_count_out
);

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_t;

    typedef logic [3:0][2:0][WORD_W-1:0] tri_t;

    state_t state;
    state_t state_next;

    // Released one clock after rst_n_in rises; asserts with rst_n_in.
    logic run;

    // Word index k kept as (row, col) so it addresses the slot directly.
    logic [1:0] row;
    logic [1:0] row_next;
    logic [1:0] col;
    logic [1:0] col_next;
    logic       index_last;

    logic [1:0] full;
    logic [1:0] full_next;
    logic       fill_ptr;
    logic       fill_ptr_next;
    logic       drain_ptr;
    logic       drain_ptr_next;

    logic       ready;
    logic       accept;
    logic       transfer;
    logic       write_en;
    logic       err_next;

    tri_t slot [2];

    assign index_last = (row == 2'd3) && (col == 2'd2);

    // Reset release synchroniser; word acceptance is gated by it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and slot bookkeeping.
    always_comb begin
        state_next     = state;
        row_next       = row;
        col_next       = col;
        full_next      = full;
        fill_ptr_next  = fill_ptr;
        drain_ptr_next = drain_ptr;
        err_next       = 1'b0;
        write_en       = 1'b0;
        ready          = 1'b0;
        accept         = 1'b0;
        transfer       = full[drain_ptr] & ready_in;

        unique case (state)
            COLLECT: ready = rst_n_in & run & ~full[fill_ptr];
            DISCARD: ready = rst_n_in & run;
            default: ready = 1'b0;
        endcase

        accept = word_valid_in & ready;

        // Drain and fill touch different slots whenever both fire, so the
        // two full-bit updates never collide.
        if (transfer) begin
            full_next[drain_ptr] = 1'b0;
            drain_ptr_next       = ~drain_ptr;
        end

        if (accept) begin
            unique case (state)
                COLLECT: begin
                    write_en = 1'b1;
                    if (index_last) begin
                        row_next = 2'd0;
                        col_next = 2'd0;
                        if (word_last_in) begin
                            full_next[fill_ptr] = 1'b1;
                            fill_ptr_next       = ~fill_ptr;
                        end else begin
                            err_next   = 1'b1;
                            state_next = DISCARD;
                        end
                    end else if (word_last_in) begin
                        row_next = 2'd0;
                        col_next = 2'd0;
                        err_next = 1'b1;
                    end else if (col == 2'd2) begin
                        col_next = 2'd0;
                        row_next = row + 2'd1;
                    end else begin
                        col_next = col + 2'd1;
                    end
                end
                DISCARD: begin
                    if (word_last_in) begin
                        state_next = COLLECT;
                    end
                end
                default: state_next = COLLECT;
            endcase
        end
    end

    // Control registers, error pulse and counters.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            row           <= '0;
            col           <= '0;
            full          <= '0;
            fill_ptr      <= 1'b0;
            drain_ptr     <= 1'b0;
            err_out       <= 1'b0;
            tri_count_out <= '0;
            err_count_out <= '0;
        end else begin
            row       <= row_next;
            col       <= col_next;
            full      <= full_next;
            fill_ptr  <= fill_ptr_next;
            drain_ptr <= drain_ptr_next;
            err_out   <= err_next;
            if (transfer) begin
                tri_count_out <= tri_count_out + CNT_W'(1);
            end
            if (err_next) begin
                err_count_out <= err_count_out + CNT_W'(1);
            end
        end
    end

    // Slot storage; contents are only meaningful while the full bit is set.
    always_ff @(posedge clk_in) begin
        if (write_en) begin
            slot[fill_ptr][row][col] <= word_in;
        end
    end

    assign word_ready_out = ready;
    assign valid_out      = full[drain_ptr];
    assign triangle_out   = slot[drain_ptr];

endmodule

// File: doc/triangle_assembler.md
TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 Parameter: WORD_W, default 32, width of one coordinate or attribute word.
REQ-002 Parameter: CNT_W, default 16, width of the triangle and error counters.
REQ-003 Port: clk_in  input  1  single clock; all logic on posedge.
REQ-004 Port: rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 Port: word_in  input  WORD_W  streamed word.
REQ-006 Port: word_valid_in  input  1  word_in is valid.
REQ-007 Port: word_last_in  input  1  word_in is the final word of a triangle record.
REQ-008 Port: word_ready_out  output  1  block accepts word_in this cycle.
REQ-009 Port: triangle_out  output  [3:0][2:0] x WORD_W  assembled triangle; rows 0-2 are vertices (x,y,z), row 3 is the attribute row.
REQ-010 Port: valid_out  output  1  triangle_out holds a complete triangle.
REQ-011 Port: ready_in  input  1  downstream pixel shader accepts triangle_out this cycle.
REQ-012 Port: tri_count_out  output  CNT_W  number of triangles handed downstream.
REQ-013 Port: err_out  output  1  one-cycle pulse on each framing error.
REQ-014 Port: err_count_out  output  CNT_W  number of framing errors.

Function
REQ-015 Word handshake: a word is accepted when word_valid_in and word_ready_out are both 1.
REQ-016 Word index k (0..11) maps to triangle[k/3][k%3]; k=0 is v1.x, k=11 is attribute[2].
REQ-017 Storage: two triangle slots in ping-pong arrangement, one fill pointer, one drain pointer, and a full bit per slot.
REQ-018 word_ready_out = 1 in state COLLECT when the fill slot is not full, and always 1 in state DISCARD; it does not depend on word_valid_in.
REQ-019 FSM COLLECT: each accepted word is written to the fill slot at index k, then k increments.
REQ-020 COLLECT, accepted word with k==11 and last=1: set the fill slot full, toggle the fill pointer, set k=0.
REQ-021 COLLECT, accepted word with k<11 and last=1: short-record error; drop the partial record, set k=0, stay in COLLECT, pulse err_out.
REQ-022 COLLECT, accepted word with k==11 and last=0: long-record error; drop the partial record, set k=0, go to DISCARD, pulse err_out.
REQ-023 DISCARD: accept and drop words until an accepted word has last=1 (that word is dropped too), then go to COLLECT; no further err_out in DISCARD.
REQ-024 valid_out = full bit of the drain slot; triangle_out = the drain slot contents, driven straight from registers.
REQ-025 Output transfer on valid_out and ready_in: clear the drain full bit, toggle the drain pointer, increment tri_count_out.
REQ-026 While valid_out=1 and ready_in=0, triangle_out and valid_out hold stable.
REQ-027 Latency: valid_out rises on the cycle after the 12th word is accepted, if the drain slot was empty.
REQ-028 Same-cycle completion of one slot and transfer from the other are both honoured.
REQ-029 With both slots full, word_ready_out=0 until a transfer occurs; word_ready_out returns to 1 on the cycle after that transfer.
REQ-030 Counters wrap modulo 2^CNT_W without saturation.
REQ-031 err_count_out increments on each err_out pulse.

Reset
REQ-032 While rst_n_in=0, immediately and asynchronously: state=COLLECT, k=0, both full bits=0, both pointers=0, valid_out=0, err_out=0, tri_count_out=0, err_count_out=0.
REQ-033 While rst_n_in=0, word_ready_out=0.
REQ-034 While rst_n_in=0, triangle_out slot contents are don't-care, but no X may reach valid_out.
REQ-035 Reset mid-record or mid-stall discards all partial and complete slots; no triangle is emitted afterwards.
REQ-036 Reset deassertion is synchronised internally; the first word can be accepted no later than the 2nd clock after deassertion.

Verification
REQ-037 12 words 1..12 with last on the 12th, ready_in=1 -> one cycle later valid_out=1, triangle_out[0][0]=1, triangle_out[3][2]=12; after transfer tri_count_out=1.
REQ-038 Three back-to-back triangles with ready_in=0 -> first two stored; word_ready_out=0 at word 0 of the third; raise ready_in -> all three emitted in order, no loss.
REQ-039 last asserted on word 5 -> err_out pulses once, err_count_out=1, no valid_out; the next clean 12-word record is emitted correctly.
REQ-040 14-word record with last on the 14th word -> err_out pulses at word 12; words 13-14 dropped; next record is correct; err_count_out=1.
REQ-041 rst_n_in pulsed low for 1 ns mid-record while valid_out=1 -> outputs clear asynchronously; the following record is emitted alone with tri_count_out=1.
REQ-042 Random word_valid_in and ready_in over 10,000 records -> the scoreboard matches every emitted triangle and the count equals the number of good records.
